// File: rtl/moving_average_ring_pkg.sv
// Shared constants and helpers for the moving-average ring filter.
package moving_avg_pkg;

  // out_mode encodings
  localparam logic OUT_SLIDING = 1'b0;
  localparam logic OUT_DECIM   = 1'b1;

  // Depth of the sample ring for a given log2 window limit.
  function automatic int calc_max_win(input int log2_max_win);
    return 1 << log2_max_win;
  endfunction

  // Accumulator width: one extra bit per doubling of the window keeps the sum exact.
  function automatic int calc_sum_width(input int data_width, input int log2_max_win);
    return data_width + log2_max_win;
  endfunction

  // Requested window exponent, limited to what the ring can hold.
  function automatic logic [7:0] clamp_k(input logic [7:0] sel, input logic [7:0] max_k);
    return (sel > max_k) ? max_k : sel;
  endfunction

endpackage

// File: rtl/moving_average_ring_if.sv
// Stream and control bundle between the sample source and the filter.
//
// Handshake: din_valid is a pure strobe with no back-pressure. A sample is
// taken on every rising edge where din_valid=1, enable=1 and clear=0.
// dout_valid is a one-cycle pulse marking the cycle in which dout changed;
// consumers must capture dout on that pulse, there is no ready signal.
interface moving_average_ring_if #(
  parameter int DATA_WIDTH = 16,
  parameter int WSEL_WIDTH = 3
);
  logic                         enable;
  logic                         clear;
  logic        [WSEL_WIDTH-1:0] win_sel;
  logic                         out_mode;
  logic                         din_valid;
  logic signed [DATA_WIDTH-1:0] din;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         win_full;

  modport master (
    output enable, clear, win_sel, out_mode, din_valid, din,
    input  dout, dout_valid, win_full
  );

  modport slave (
    input  enable, clear, win_sel, out_mode, din_valid, din,
    output dout, dout_valid, win_full
  );
endinterface

// File: rtl/moving_average_ring_ring.sv
// Circular sample store: one write port at wr_ptr, combinational read of the
// sample that sits rd_off entries behind wr_ptr (the one leaving the window).
module ma_sample_ring
  import moving_avg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_MAX_WIN = 4
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic        [LOG2_MAX_WIN-1:0] wr_ptr,
  input  logic        [LOG2_MAX_WIN-1:0] rd_off,
  input  logic signed [DATA_WIDTH-1:0]   wdata,
  output logic signed [DATA_WIDTH-1:0]   rd_data
);

  localparam int DEPTH = calc_max_win(LOG2_MAX_WIN);

  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic        [LOG2_MAX_WIN-1:0] rd_idx;

  // Index arithmetic wraps naturally; an offset of a full ring reads wr_ptr itself.
  assign rd_idx  = wr_ptr - rd_off;
  assign rd_data = mem_q[rd_idx];

  // Sample storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/moving_average_ring.sv
// Exact sliding boxcar mean over the last 2^k signed samples, k chosen at run
// time. Keeps a running sum, adds each new sample and subtracts the one that
// drops out of the window, then rounds and shifts by k for the mean.
module moving_average_ring
  import moving_avg_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LOG2_MAX_WIN = 4,
  parameter int WSEL_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  moving_average_ring_if.slave  bus
);

  localparam int SW = calc_sum_width(DATA_WIDTH, LOG2_MAX_WIN);
  localparam int FW = LOG2_MAX_WIN + 1;
  localparam int AW = LOG2_MAX_WIN;

  logic        [WSEL_WIDTH-1:0] k_sel, k_q, k_d;
  logic        [FW-1:0]         n_win;
  logic        [FW-1:0]         fill_q, fill_d, fill_base;
  logic        [FW-1:0]         dec_q, dec_d, dec_base;
  logic        [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic signed [SW-1:0]         sum_q, sum_d, sum_base, next_sum, round_bias, rounded;
  logic signed [DATA_WIDTH-1:0] dout_q, dout_d, oldest;
  logic                         dout_valid_q, dout_valid_d;
  logic                         win_full_q, win_full_d;
  logic                         win_change, accept, ring_we, old_full;

  // Window exponent after clamping, and the window length it implies.
  assign k_sel      = WSEL_WIDTH'(clamp_k(8'(bus.win_sel), 8'(LOG2_MAX_WIN)));
  assign n_win      = FW'(1) << k_sel;
  assign win_change = (k_sel != k_q);
  assign accept     = bus.enable & bus.din_valid & ~bus.clear;

  // A window change flushes, but a sample in the same cycle still starts the new window.
  assign sum_base  = win_change ? '0 : sum_q;
  assign fill_base = win_change ? '0 : fill_q;
  assign dec_base  = win_change ? '0 : dec_q;
  assign old_full  = (fill_base == n_win);

  // Half-LSB of the shifted result, so the shift rounds half toward +inf.
  assign round_bias = (k_sel == '0) ? '0 : (SW'(1) << (k_sel - 1'b1));

  ma_sample_ring #(
    .DATA_WIDTH   (DATA_WIDTH),
    .LOG2_MAX_WIN (LOG2_MAX_WIN)
  ) u_ring (
    .clk     (clk),
    .we      (ring_we),
    .wr_ptr  (wr_ptr_q),
    .rd_off  (n_win[AW-1:0]),
    .wdata   (bus.din),
    .rd_data (oldest)
  );

  // Next-state for sum, fill, decimation count, write pointer and outputs.
  always_comb begin
    k_d          = k_sel;
    sum_d        = sum_q;
    fill_d       = fill_q;
    dec_d        = dec_q;
    wr_ptr_d     = wr_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    win_full_d   = win_full_q;
    next_sum     = '0;
    rounded      = '0;
    ring_we      = 1'b0;
    if (bus.clear) begin
      sum_d      = '0;
      fill_d     = '0;
      dec_d      = '0;
      win_full_d = 1'b0;
    end else if (accept) begin
      ring_we    = 1'b1;
      wr_ptr_d   = wr_ptr_q + 1'b1;
      next_sum   = sum_base + SW'(bus.din) - (old_full ? SW'(oldest) : SW'(0));
      sum_d      = next_sum;
      fill_d     = old_full ? n_win : fill_base + 1'b1;
      dec_d      = (dec_base == n_win - 1'b1) ? '0 : dec_base + 1'b1;
      win_full_d = (fill_d == n_win);
      if ((fill_d == n_win) &&
          ((bus.out_mode == OUT_SLIDING) || (dec_base == n_win - 1'b1))) begin
        dout_valid_d = 1'b1;
        rounded      = next_sum + round_bias;
        dout_d       = DATA_WIDTH'(rounded >>> k_sel);
      end
    end else if (win_change) begin
      sum_d      = '0;
      fill_d     = '0;
      dec_d      = '0;
      win_full_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q          <= '0;
      sum_q        <= '0;
      fill_q       <= '0;
      dec_q        <= '0;
      wr_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      win_full_q   <= 1'b0;
    end else begin
      k_q          <= k_d;
      sum_q        <= sum_d;
      fill_q       <= fill_d;
      dec_q        <= dec_d;
      wr_ptr_q     <= wr_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      win_full_q   <= win_full_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.win_full   = win_full_q;

endmodule

// File: tb/tb_moving_average_ring.sv
// Directed bench for moving_average_ring with hand-computed expectations.
module tb_moving_average_ring;

  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  moving_average_ring_if #(.DATA_WIDTH(DW), .WSEL_WIDTH(3)) bus ();

  moving_average_ring #(
    .DATA_WIDTH   (DW),
    .LOG2_MAX_WIN (4),
    .WSEL_WIDTH   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  int n_total   = 0;
  int n_bad     = 0;
  int pulse_cnt = 0;
  int base;
  logic [DW-1:0]        exp_q[$];
  logic signed [DW-1:0] exp_v;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Every dout_valid pulse must match the next queued expected mean.
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1) begin
      pulse_cnt++;
      check("pulse_has_exp", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("dout", bus.dout, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int v);
    bus.din       = DW'(v);
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.enable    = 1'b1;
    bus.clear     = 1'b0;
    bus.win_sel   = 3'd0;
    bus.out_mode  = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    idle(2);
    check("rst_dout", bus.dout, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_win_full", bus.win_full, 0);
    rst = 1'b0;

    // k=2 sliding: 4,8,12,16,20 -> means 10, 14
    bus.win_sel = 3'd2;
    idle(2);
    base = pulse_cnt;
    for (int i = 1; i <= 3; i++) push(4 * i);
    settle();
    check("t1_no_pulse_early", pulse_cnt - base, 0);
    check("t1_not_full", bus.win_full, 0);
    exp_q.push_back(16'd10);
    exp_q.push_back(16'd14);
    push(16);
    push(20);
    settle();
    check("t1_pulses", pulse_cnt - base, 2);
    check("t1_full", bus.win_full, 1);

    // explicit clear, then k=2 decimated with 8 x 100
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
    check("clr_win_full", bus.win_full, 0);
    check("clr_dout_held", bus.dout, 14);
    bus.out_mode = 1'b1;
    base = pulse_cnt;
    exp_q.push_back(16'd100);
    exp_q.push_back(16'd100);
    for (int i = 0; i < 3; i++) push(100);
    settle();
    check("t2_before_4th", pulse_cnt - base, 0);
    push(100);
    settle();
    check("t2_at_4th", pulse_cnt - base, 1);
    for (int i = 0; i < 3; i++) push(100);
    settle();
    check("t2_before_8th", pulse_cnt - base, 1);
    push(100);
    settle();
    check("t2_at_8th", pulse_cnt - base, 2);

    // rounding, k=1 sliding: -3,-2 -> -2 ; 1 -> 0 ; 2 -> 2
    bus.out_mode = 1'b0;
    bus.win_sel  = 3'd1;
    idle(2);
    base = pulse_cnt;
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd2);
    push(-3);
    push(-2);
    push(1);
    push(2);
    settle();
    check("t3_pulses", pulse_cnt - base, 3);

    // extremes: win_sel=7 clamps to 16-deep window, decimated
    bus.win_sel  = 3'd7;
    bus.out_mode = 1'b1;
    idle(2);
    base = pulse_cnt;
    exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'h8000);
    for (int i = 0; i < 16; i++) push(32767);
    settle();
    check("t4_full_max", bus.win_full, 1);
    check("t4_pulse_max", pulse_cnt - base, 1);
    for (int i = 0; i < 16; i++) push(-32768);
    settle();
    check("t4_pulse_min", pulse_cnt - base, 2);

    // window change 2 -> 3 mid-stream with a sample in the change cycle
    bus.out_mode = 1'b0;
    bus.win_sel  = 3'd2;
    idle(2);
    base = pulse_cnt;
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd4);
    exp_q.push_back(16'd9);
    for (int i = 1; i <= 5; i++) push(i);
    settle();
    check("t5_old_pulses", pulse_cnt - base, 2);
    bus.win_sel = 3'd3;
    push(2);
    settle();
    check("t5_full_drop", bus.win_full, 0);
    for (int i = 2; i <= 7; i++) push(2 * i);
    settle();
    check("t5_no_pulse_7", pulse_cnt - base, 2);
    push(16);
    settle();
    check("t5_pulse_8", pulse_cnt - base, 3);
    check("t5_full", bus.win_full, 1);

    // asynchronous reset between accepts
    rst = 1'b1;
    #2;
    check("rst2_dout", bus.dout, 0);
    check("rst2_win_full", bus.win_full, 0);
    check("rst2_dout_valid", bus.dout_valid, 0);
    rst = 1'b0;
    base = pulse_cnt;
    exp_q.push_back(16'd7);
    for (int i = 0; i < 7; i++) push(7);
    settle();
    check("t6_refill", pulse_cnt - base, 0);
    push(7);
    settle();
    check("t6_pulse", pulse_cnt - base, 1);

    // clear together with din_valid drops the sample
    base = pulse_cnt;
    bus.clear = 1'b1;
    push(100);
    bus.clear = 1'b0;
    settle();
    check("t7_win_full", bus.win_full, 0);
    check("t7_dout_held", bus.dout, 7);
    check("t7_no_pulse", pulse_cnt - base, 0);
    exp_q.push_back(16'd1);
    for (int i = 0; i < 7; i++) push(1);
    settle();
    check("t7_refill", pulse_cnt - base, 0);
    push(1);
    settle();
    check("t7_pulse", pulse_cnt - base, 1);

    // enable=0 ignores din_valid and holds everything
    base = pulse_cnt;
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) push(50);
    settle();
    check("t8_no_pulse", pulse_cnt - base, 0);
    check("t8_dout_held", bus.dout, 1);
    check("t8_full_held", bus.win_full, 1);
    bus.enable = 1'b1;
    exp_q.push_back(16'd2);
    push(9);
    settle();
    check("t8_pulse", pulse_cnt - base, 1);

    // k=0 passes samples straight through
    bus.win_sel = 3'd0;
    idle(2);
    base = pulse_cnt;
    exp_q.push_back(16'd5);
    exp_q.push_back(16'hFFF9);
    push(5);
    push(-7);
    settle();
    check("t9_pulses", pulse_cnt - base, 2);

    idle(2);
    check("exp_q_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
